axi4lite_cmd_engine: RTL

Parametrised successor to the fixed 8-bit, 4-register AXI4-Lite loopback. It contains a command-driven AXI4-Lite master and an internal register-file slave. A user command port issues one read or write at a time and receives a response with data and error status. The block adds configurable data width, address width and register count, byte strobes, SLVERR for out-of-range addresses, and a proper valid/ready command and response handshake. It sits between the pad-level wrapper and the user logic.

---
 rtl/axi4lite_pkg.sv | 24 ++
 rtl/axi4lite_regfile_slave.sv | 118 +++++++++++
 rtl/axi4lite_cmd_engine.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/axi4lite_pkg.sv
// Shared definitions for the AXI4-Lite command engine: response codes,
// master state encoding and a constant-evaluable log2 helper.
package axi4lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_BRESP,
      ST_AR,
      ST_RDATA,
      ST_RSP
   } mst_state_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite register-file slave with byte strobes and SLVERR for indices
// beyond NUM_REGS. One transaction at a time; responses held until accepted.
module axi4lite_regfile_slave
   import axi4lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic                    wvalid,
   output logic                    wready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    bvalid,
   input  logic                    bready,
   output logic [1:0]              bresp,
   input  logic                    arvalid,
   output logic                    arready,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   output logic                    rvalid,
   input  logic                    rready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int LSB    = clog2(STRB_W);
   localparam int IDX_W  = ADDR_WIDTH - LSB;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;

   logic [IDX_W-1:0]      aw_idx, ar_idx;
   logic                  aw_hit, ar_hit;
   logic                  wr_fire, rd_fire;
   logic [DATA_WIDTH-1:0] rd_sel;

   assign aw_idx  = awaddr[ADDR_WIDTH-1:LSB];
   assign ar_idx  = araddr[ADDR_WIDTH-1:LSB];
   assign aw_hit  = 32'(aw_idx) < NUM_REGS;
   assign ar_hit  = 32'(ar_idx) < NUM_REGS;

   // Address and data are accepted together, and never while a B response is pending.
   assign wr_fire = awvalid & wvalid & ~bvalid_q;
   assign rd_fire = arvalid & ~rvalid_q;
   assign awready = wr_fire;
   assign wready  = wr_fire;
   assign arready = rd_fire;

   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;

   always_comb begin
      regs_d   = regs_q;
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      rd_sel   = '0;

      for (int r = 0; r < NUM_REGS; r++) begin
         if (ar_idx == IDX_W'(r)) rd_sel = regs_q[r];
      end

      if (bvalid_q && bready) bvalid_d = 1'b0;
      if (wr_fire) begin
         bvalid_d = 1'b1;
         bresp_d  = aw_hit ? RESP_OKAY : RESP_SLVERR;
         for (int r = 0; r < NUM_REGS; r++) begin
            if (aw_hit && aw_idx == IDX_W'(r)) begin
               for (int b = 0; b < STRB_W; b++) begin
                  if (wstrb[b]) regs_d[r][8*b +: 8] = wdata[8*b +: 8];
               end
            end
         end
      end

      if (rvalid_q && rready) rvalid_d = 1'b0;
      if (rd_fire) begin
         rvalid_d = 1'b1;
         rdata_d  = ar_hit ? rd_sel : '0;
         rresp_d  = ar_hit ? RESP_OKAY : RESP_SLVERR;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else begin
         regs_q   <= regs_d;
         bvalid_q <= bvalid_d;
         bresp_q  <= bresp_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rresp_q  <= rresp_d;
      end
   end

endmodule

// File: rtl/axi4lite_cmd_engine.sv
// Command-driven AXI4-Lite master wrapped around an internal register-file
// slave. One command in flight; response held until rsp_ready.
module axi4lite_cmd_engine
   import axi4lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic                    busy
);

   mst_state_e              state_q;
   logic                    cmd_ready_q, busy_q;
   logic                    awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH/8-1:0] wstrb_q;
   logic                    rsp_valid_q, rsp_err_q;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q;

   logic                    awready, wready, bvalid, arready, rvalid;
   logic [1:0]              bresp, rresp;
   logic [DATA_WIDTH-1:0]   rdata;
   // Only bit 1 of a response distinguishes an error; bit 0 is intentionally dropped.
   logic                    unused_resp_lsb;

   assign unused_resp_lsb = bresp[0] ^ rresp[0];

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   axi4lite_regfile_slave #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS)
   ) u_slave (
      .clk     (clk),
      .rst_n   (rst_n),
      .awvalid (awvalid_q),
      .awready (awready),
      .awaddr  (addr_q),
      .wvalid  (wvalid_q),
      .wready  (wready),
      .wdata   (wdata_q),
      .wstrb   (wstrb_q),
      .bvalid  (bvalid),
      .bready  (bready_q),
      .bresp   (bresp),
      .arvalid (arvalid_q),
      .arready (arready),
      .araddr  (addr_q),
      .rvalid  (rvalid),
      .rready  (rready_q),
      .rdata   (rdata),
      .rresp   (rresp)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  addr_q      <= cmd_addr;
                  wdata_q     <= cmd_wdata;
                  wstrb_q     <= cmd_wstrb;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b0;
                  if (cmd_write) begin
                     state_q   <= ST_WR;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                  end else begin
                     state_q   <= ST_AR;
                     arvalid_q <= 1'b1;
                  end
               end
            end
            ST_WR: begin
               if (awready) awvalid_q <= 1'b0;
               if (wready)  wvalid_q  <= 1'b0;
               // A channel counts as done once its valid has dropped or it handshakes now.
               if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
                  state_q  <= ST_BRESP;
                  bready_q <= 1'b1;
               end
            end
            ST_BRESP: begin
               if (bvalid) begin
                  bready_q    <= 1'b0;
                  rsp_err_q   <= bresp[1];
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RSP;
               end
            end
            ST_AR: begin
               if (arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= ST_RDATA;
               end
            end
            ST_RDATA: begin
               if (rvalid) begin
                  rready_q    <= 1'b0;
                  rsp_rdata_q <= rdata;
                  rsp_err_q   <= rresp[1];
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RSP;
               end
            end
            ST_RSP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
